// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, serviced LATENCY cycles after accept.
// Optional per-byte store masking when DMEM_BYTE_WRITE_EN is defined (adds req_be_i).
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  req_be_i,
`endif
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready_o is high only in IDLE; resp_valid_o holds with stable rdata/err until resp_ready_i.

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_ready_q, req_ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               cap_write_q, cap_write_d;
    logic [ADDR_W-1:0]  cap_idx_q, cap_idx_d;
    logic [31:0]        cap_wdata_q, cap_wdata_d;
    logic               cap_err_q, cap_err_d;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]         cap_be_q, cap_be_d;
`endif

    logic [31:0]        mem_q [DEPTH];
    logic               commit;
    logic               mem_we;
    logic               addr_err;

    // Misaligned, or any byte-address bit above the word index is set.
    assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:ADDR_W+2] != '0);

    assign commit = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we = commit && cap_write_q && !cap_err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        cap_write_d  = cap_write_q;
        cap_idx_d    = cap_idx_q;
        cap_wdata_d  = cap_wdata_q;
        cap_err_d    = cap_err_q;
`ifdef DMEM_BYTE_WRITE_EN
        cap_be_d     = cap_be_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    cap_write_d = req_write_i;
                    cap_idx_d   = req_addr_i[ADDR_W+1:2];
                    cap_wdata_d = req_wdata_i;
                    cap_err_d   = addr_err;
`ifdef DMEM_BYTE_WRITE_EN
                    cap_be_d    = req_be_i;
`endif
                    cnt_d       = LAT_M1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    err_d        = cap_err_q;
                    rdata_d      = (!cap_write_q && !cap_err_q) ? mem_q[cap_idx_q] : 32'h0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    rdata_d      = 32'h0;
                    err_d        = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                rdata_d      = 32'h0;
                err_d        = 1'b0;
            end
        endcase
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            cap_write_q  <= 1'b0;
            cap_idx_q    <= '0;
            cap_wdata_q  <= 32'h0;
            cap_err_q    <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
            cap_be_q     <= 4'h0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            cap_write_q  <= cap_write_d;
            cap_idx_q    <= cap_idx_d;
            cap_wdata_q  <= cap_wdata_d;
            cap_err_q    <= cap_err_d;
`ifdef DMEM_BYTE_WRITE_EN
            cap_be_q     <= cap_be_d;
`endif
        end
    end

    // Storage has no reset; a reset in BUSY forces state_q to IDLE, so mem_we cannot fire.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef DMEM_BYTE_WRITE_EN
            for (int b = 0; b < 4; b++) begin
                if (cap_be_q[b]) begin
                    mem_q[cap_idx_q][8*b +: 8] <= cap_wdata_q[8*b +: 8];
                end
            end
`else
            mem_q[cap_idx_q] <= cap_wdata_q;
`endif
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: table of load/store vectors plus hand-written reset and
// LATENCY=1 throughput sequences.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dbg_state;

    logic        l1_req_valid, l1_req_ready, l1_resp_valid, l1_resp_err;
    logic [31:0] l1_resp_rdata;
    logic [1:0]  l1_dbg_state;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(LAT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be_i     (req_be),
`endif
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .dbg_state_o  (dbg_state)
    );

    dmem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1)) u_lat1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (l1_req_valid),
        .req_ready_o  (l1_req_ready),
        .req_write_i  (1'b0),
        .req_addr_i   (32'h0),
        .req_wdata_i  (32'h0),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be_i     (4'hF),
`endif
        .resp_valid_o (l1_resp_valid),
        .resp_ready_i (1'b1),
        .resp_rdata_o (l1_resp_rdata),
        .resp_err_o   (l1_resp_err),
        .dbg_state_o  (l1_dbg_state)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          hold;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int hold, input logic e_err,
                           input logic [31:0] e_rdata);
        vec_t v;
        v.write = wr; v.addr = addr; v.wdata = wdata; v.be = be;
        v.hold = hold; v.exp_err = e_err; v.exp_rdata = e_rdata;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic do_req(input vec_t v, input int idx);
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        // Scramble sampled-at-accept inputs; the response must not follow them.
        req_valid = 1'b0;
        req_write = ~v.write;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, LAT);
        check({tag, " err"}, {31'h0, resp_err}, {31'h0, v.exp_err});
        check({tag, " rdata"}, resp_rdata, v.exp_rdata);
        check({tag, " req_ready busy"}, {31'h0, req_ready}, 32'h0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check({tag, " hold valid"}, {31'h0, resp_valid}, 32'h1);
            check({tag, " hold rdata"}, resp_rdata, v.exp_rdata);
            check({tag, " hold req_ready"}, {31'h0, req_ready}, 32'h0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, " post valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, " post rdata"}, resp_rdata, 32'h0);
        check({tag, " post err"}, {31'h0, resp_err}, 32'h0);
        check({tag, " post req_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    task automatic store_then_reset(input logic [31:0] addr, input logic [31:0] data,
                                    input logic in_resp, input string tag);
        int n;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_be    = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, " state busy"}, {30'h0, dbg_state}, 32'd1);
        if (in_resp) begin
            n = 0;
            while (!resp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({tag, " state resp"}, {30'h0, dbg_state}, 32'd2);
        end
        rst = 1'b1;
        #1;
        check({tag, " rst state"}, {30'h0, dbg_state}, 32'd0);
        check({tag, " rst valid"}, {31'h0, resp_valid}, 32'h0);
        check({tag, " rst req_ready"}, {31'h0, req_ready}, 32'h1);
        check({tag, " rst rdata"}, resp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [31:0] be_exp;
        logic [1:0]  rr_pat [9];
        int          rr_exp, rv_exp;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0;
        l1_req_valid = 1'b0;

`ifdef DMEM_BYTE_WRITE_EN
        be_exp = 32'hAABBCC11;
`else
        be_exp = 32'h00000011;
`endif
        //      wr    addr           wdata          be    hold err   rdata
        add_vec(1'b1, 32'h0000_0000, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0);
        add_vec(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0);
        add_vec(1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b0, 32'h0000_0010, 32'h0,         4'h0, 5, 1'b0, 32'hDEAD_BEEF);
        add_vec(1'b0, 32'h0000_0012, 32'h0,         4'hF, 0, 1'b1, 32'h0);
        add_vec(1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF, 0, 1'b1, 32'h0);
        add_vec(1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'hF, 0, 1'b1, 32'h0);
        add_vec(1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 1'b0, 32'h1234_5678);
        add_vec(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'h0);
        add_vec(1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 2, 1'b0, 32'hA5A5_A5A5);
        add_vec(1'b0, 32'h0000_1000, 32'h0,         4'h0, 0, 1'b1, 32'h0);
        add_vec(1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'hF, 0, 1'b0, 32'h0);
        add_vec(1'b1, 32'h0000_0040, 32'h0000_0011, 4'h1, 0, 1'b0, 32'h0);
        add_vec(1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 1'b0, be_exp);
        add_vec(1'b1, 32'h0000_0020, 32'h5566_7788, 4'hF, 0, 1'b0, 32'h0);
        add_vec(1'b1, 32'h0000_0024, 32'h0102_0304, 4'hF, 0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        check("reset state", {30'h0, dbg_state}, 32'd0);
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset err", {31'h0, resp_err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            v = vecs[i];
            do_req(v, i);
        end

        // Reset while BUSY: the uncommitted store must never land.
        store_then_reset(32'h0000_0020, 32'h1122_3344, 1'b0, "rst_busy");
        v.write = 1'b0; v.addr = 32'h20; v.wdata = 0; v.be = 0; v.hold = 0;
        v.exp_err = 1'b0; v.exp_rdata = 32'h5566_7788;
        do_req(v, 100);

        // Reset while RESP: the store already committed must stay.
        store_then_reset(32'h0000_0024, 32'h0BAD_CAFE, 1'b1, "rst_resp");
        v.addr = 32'h24; v.exp_rdata = 32'h0BAD_CAFE;
        do_req(v, 101);

        // LATENCY=1 with resp_ready tied high: one response every 3 cycles.
        @(negedge clk);
        rst = 1'b1;
        l1_req_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            rr_exp = (i % 3 == 0) ? 1 : 0;
            rv_exp = (i % 3 == 2) ? 1 : 0;
            rr_pat[i] = {l1_req_ready, l1_resp_valid};
            check($sformatf("lat1 req_ready c%0d", i), {31'h0, rr_pat[i][1]}, rr_exp);
            check($sformatf("lat1 resp_valid c%0d", i), {31'h0, rr_pat[i][0]}, rv_exp);
            if (rv_exp == 1) check($sformatf("lat1 err c%0d", i), {31'h0, l1_resp_err}, 32'h0);
        end
        l1_req_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
